modulo_accumulate_reduce: RTL and testbench



---
 rtl/modulo_accumulate_reduce_pkg.sv | 14 +
 rtl/modulo_accumulate_reduce_modadd_csub.sv | 23 ++
 rtl/modulo_accumulate_reduce.sv | 125 ++++++++++++
 tb/tb_modulo_accumulate_reduce.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/modulo_accumulate_reduce_pkg.sv
// rtl/modulo_accumulate_reduce_pkg.sv - shared types and width helpers for residue accumulation
package modulo_accumulate_reduce_pkg;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } mar_state_t;

    // Width needed to hold a term count from 0 up to and including maxterms.
    function automatic int count_width(input int maxterms);
        return $clog2(maxterms + 1);
    endfunction

endpackage

// File: rtl/modulo_accumulate_reduce_modadd_csub.sv
// rtl/modulo_accumulate_reduce_modadd_csub.sv - one-step modular add with single conditional subtract
module modadd_csub #(
    parameter int MODULUS     = 1021,
    parameter int MODBITWIDTH = 10
) (
    input  logic [MODBITWIDTH-1:0] a,
    input  logic [MODBITWIDTH-1:0] b,
    output logic [MODBITWIDTH-1:0] sum
);

    localparam logic [MODBITWIDTH:0] MOD_EXT = (MODBITWIDTH+1)'(MODULUS);

    logic [MODBITWIDTH:0] s;
    logic                 ge;

    // Full-width add, then subtract the modulus once when the sum reaches it.
    always_comb begin
        s   = {1'b0, a} + {1'b0, b};
        ge  = (s >= MOD_EXT);
        sum = MODBITWIDTH'(ge ? (s - MOD_EXT) : s);
    end

endmodule

// File: rtl/modulo_accumulate_reduce.sv
// rtl/modulo_accumulate_reduce.sv - accumulates residue terms mod MODULUS and presents group results
module modulo_accumulate_reduce
    import modulo_accumulate_reduce_pkg::*;
#(
    parameter int MODULUS     = 1021,
    parameter int MODBITWIDTH = 10,
    parameter int MAXTERMS    = 64,
    localparam int COUNTW     = count_width(MAXTERMS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MODBITWIDTH-1:0] in_term,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [MODBITWIDTH-1:0] out_value,
    output logic [COUNTW-1:0]      out_count,
    output logic                   out_err
);

    localparam logic [MODBITWIDTH-1:0] MOD_W = MODBITWIDTH'(MODULUS);
    localparam logic [COUNTW-1:0]      MAX_C = COUNTW'(MAXTERMS);

    mar_state_t state, state_next;

    logic [MODBITWIDTH-1:0] acc;
    logic [MODBITWIDTH-1:0] acc_next;
    logic [COUNTW-1:0]      count;
    logic [COUNTW-1:0]      count_inc;
    logic                   err;
    logic                   term_fire;
    logic                   out_fire;
    logic                   range_bad;
    logic                   count_full;
    logic                   viol;

    modadd_csub #(
        .MODULUS     (MODULUS),
        .MODBITWIDTH (MODBITWIDTH)
    ) u_modadd (
        .a   (acc),
        .b   (in_term),
        .sum (acc_next)
    );

    // Handshake flags decoded from registered state only, so out_ready never reaches in_ready.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_ACC: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_ACC;
                end
            end
            default: state_next = ST_ACC;
        endcase
    end

    // Per-term violation detection and saturating count.
    always_comb begin
        term_fire  = in_valid & in_ready;
        out_fire   = out_valid & out_ready;
        range_bad  = (in_term >= MOD_W);
        count_full = (count == MAX_C);
        viol       = range_bad | count_full;
        count_inc  = count_full ? count : count + COUNTW'(1);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_ACC;
        end else begin
            state <= state_next;
        end
    end

    // Group accumulator; cleared as the closing term hands its result to the output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc   <= '0;
            count <= '0;
            err   <= 1'b0;
        end else if (term_fire) begin
            if (in_last) begin
                acc   <= '0;
                count <= '0;
                err   <= 1'b0;
            end else begin
                acc   <= acc_next;
                count <= count_inc;
                err   <= err | viol;
            end
        end
    end

    // Result registers, loaded only by the closing term and held until the next group closes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_value <= '0;
            out_count <= '0;
            out_err   <= 1'b0;
        end else if (term_fire && in_last) begin
            out_value <= acc_next;
            out_count <= count_inc;
            out_err   <= err | viol;
        end
    end

    // Output transfer only changes state; the result registers simply stop being presented.
    logic unused_out_fire;
    assign unused_out_fire = out_fire;

endmodule

// File: tb/tb_modulo_accumulate_reduce.sv
// tb/tb_modulo_accumulate_reduce.sv - randomized self-checking bench against a behavioural model
module tb_modulo_accumulate_reduce;

    localparam int M     = 1021;
    localparam int W     = 10;
    localparam int MAXT  = 64;
    localparam int CW    = $clog2(MAXT + 1);

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_term;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_value;
    logic [CW-1:0] out_count;
    logic          out_err;

    int checks;
    int failures;
    int grp[$];

    modulo_accumulate_reduce #(
        .MODULUS     (M),
        .MODBITWIDTH (W),
        .MAXTERMS    (MAXT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_term   (in_term),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_count (out_count),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drives grp as one group starting at a negedge; checks the result, applies
    // bp cycles of backpressure, completes the transfer and returns at a negedge.
    task automatic send_group(input int bp, input bit gaps);
        longint sum;
        int     n;
        int     exp_cnt;
        bit     exp_err;
        bit     val_known;
        int     wait_cnt;
        n         = grp.size();
        sum       = 0;
        exp_err   = (n > MAXT);
        val_known = 1'b1;
        foreach (grp[k]) begin
            sum += grp[k];
            if (grp[k] >= M) begin
                exp_err   = 1'b1;
                val_known = 1'b0;
            end
        end
        exp_cnt = (n > MAXT) ? MAXT : n;

        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_last  = 1'($urandom);
                    in_term  = W'($urandom);
                    @(negedge clk);
                    check("idle_no_valid", out_valid, 0);
                end
            end
            in_valid = 1'b1;
            in_term  = W'(grp[i]);
            in_last  = (i == n - 1);
            wait_cnt = 0;
            while (!in_ready && wait_cnt < 100) begin
                @(negedge clk);
                wait_cnt++;
            end
            if (!in_ready) begin
                check("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (i < n - 1) check("no_early_valid", out_valid, 0);
        end

        check("result_valid", out_valid, 1);
        check("result_in_ready", in_ready, 0);
        if (val_known) check("result_value", out_value, int'(sum % M));
        check("result_count", out_count, exp_cnt);
        check("result_err", out_err, exp_err);

        for (int c = 0; c < bp; c++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            if (val_known) check("bp_value", out_value, int'(sum % M));
            check("bp_count", out_count, exp_cnt);
            check("bp_err", out_err, exp_err);
        end

        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("post_xfer_in_ready", in_ready, 1);
        check("post_xfer_valid", out_valid, 0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_term   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_value", out_value, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_err", out_err, 0);
        reset_n = 1'b1;
        @(negedge clk);

        grp = '{1000, 1000, 500};
        send_group(0, 1'b0);
        check("plan_458", out_value, 458);

        grp = '{21, 1000};
        send_group(0, 1'b0);
        check("plan_eq_mod", out_value, 0);

        grp = '{1020};
        send_group(0, 1'b0);
        check("plan_single", out_value, 1020);
        check("plan_single_cnt", out_count, 1);

        grp = '{5, 1021};
        send_group(0, 1'b0);
        check("plan_range_err", out_err, 1);
        check("plan_range_cnt", out_count, 2);

        grp = '{7};
        send_group(5, 1'b0);
        check("plan_err_cleared", out_err, 0);
        check("plan_clean_val", out_value, 7);

        grp = '{11, 22};
        send_group(0, 1'b0);

        grp.delete();
        for (int i = 0; i < MAXT + 1; i++) grp.push_back(1);
        send_group(1, 1'b0);
        check("plan_ovf_err", out_err, 1);
        check("plan_ovf_cnt", out_count, MAXT);

        grp.delete();
        for (int i = 0; i < MAXT; i++) grp.push_back(M - 1);
        send_group(0, 1'b0);
        check("full_no_err", out_err, 0);

        // Abort a group with reset after two accepted terms.
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_term  = W'(100 + i);
            in_last  = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check("abort_valid_now", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_valid", out_valid, 0);
        end
        grp = '{3};
        send_group(0, 1'b0);
        check("abort_then_3", out_value, 3);

        for (int g = 0; g < 25; g++) begin
            int n;
            n = $urandom_range(1, 12);
            grp.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 19) == 0) grp.push_back($urandom_range(M, (1 << W) - 1));
                else grp.push_back($urandom_range(0, M - 1));
            end
            send_group($urandom_range(0, 3), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

endmodule
